// File: rtl/clk_div_meter.sv
// clk_div_meter: measures period and high time of a divided clock sampled on sys_clk and tracks period lock.
// Optional CLK_DIV_METER_SYNC_IN_EN inserts a 2-flop synchroniser ahead of the sampling register.
module clk_div_meter #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             clk_in,
    output logic [CNT_W:0]   period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             err
);
    localparam int                MW      = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0]     LOCK_M  = MW'(LOCK_CNT);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic {WAIT_EDGE, MEASURE} state_t;

    state_t            state_q, state_d;
    logic              samp_in, samp_p0, samp_p1, rise;
    logic [CNT_W-1:0]  hi_cnt, lo_cnt;
    logic [CNT_W:0]    last_period, new_period;
    logic              prev_vld;
    logic [MW-1:0]     match_cnt, new_match;
    logic              publish, timeout;

    function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
        return (v == LOCK_M) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W:0] wide_sum(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

`ifdef CLK_DIV_METER_SYNC_IN_EN
    logic sync_p0, sync_p1;
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= clk_in;
            sync_p1 <= sync_p0;
        end
    end
    assign samp_in = sync_p1;
`else
    assign samp_in = clk_in;
`endif

    // Stage p0/p1: sample and delay; both reset high so a high input at release is not a rise
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            samp_p0 <= 1'b1;
            samp_p1 <= 1'b1;
        end else begin
            samp_p0 <= samp_in;
            samp_p1 <= samp_p0;
        end
    end

    assign rise = samp_p0 & ~samp_p1;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= WAIT_EDGE;
        else         state_q <= state_d;
    end

    // A rise coinciding with a saturated counter publishes rather than timing out
    always_comb begin
        state_d = state_q;
        publish = 1'b0;
        timeout = 1'b0;
        case (state_q)
            WAIT_EDGE: if (rise) state_d = MEASURE;
            MEASURE: begin
                if (rise) begin
                    publish = 1'b1;
                end else if (hi_cnt == CNT_MAX || lo_cnt == CNT_MAX) begin
                    timeout = 1'b1;
                    state_d = WAIT_EDGE;
                end
            end
            default: state_d = WAIT_EDGE;
        endcase
    end

    assign new_period = wide_sum(hi_cnt, lo_cnt);
    assign new_match  = (prev_vld && new_period == last_period) ? sat_inc(match_cnt) : '0;

    // Phase counters: the rise cycle itself is the first high cycle
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else if (rise) begin
            hi_cnt <= CNT_W'(1);
            lo_cnt <= '0;
        end else if (state_q == MEASURE && !timeout) begin
            if (samp_p0) hi_cnt <= hi_cnt + 1'b1;
            else         lo_cnt <= lo_cnt + 1'b1;
        end
    end

    // Stage p2: published measurement, lock tracking and timeout flag
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            period      <= '0;
            high_time   <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
            match_cnt   <= '0;
            last_period <= '0;
            prev_vld    <= 1'b0;
        end else begin
            meas_valid <= publish;
            if (publish) begin
                period      <= new_period;
                high_time   <= hi_cnt;
                err         <= 1'b0;
                match_cnt   <= new_match;
                locked      <= (new_match == LOCK_M);
                last_period <= new_period;
                prev_vld    <= 1'b1;
            end else if (timeout) begin
                err       <= 1'b1;
                locked    <= 1'b0;
                match_cnt <= '0;
                prev_vld  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_clk_div_meter.sv
// Scoreboard bench for clk_div_meter: stimulus is a list of (high, low) periods, a period-level model
// pushes expected strobes and timeouts, and a monitor pops them as the DUT reports.
module tb_clk_div_meter;
    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;
    localparam int SAT      = (1 << CNT_W) - 1;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             clk_in  = 1'b1;
    logic [CNT_W:0]   period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid, locked, err;

    clk_div_meter #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clk_in(clk_in),
        .period(period), .high_time(high_time), .meas_valid(meas_valid),
        .locked(locked), .err(err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit tmo;
        int per;
        int hi;
        int lk;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state, one step per rising edge of the waveform
    bit m_meas = 0, m_have_prev = 0, m_err = 0;
    int m_last = 0, m_match = 0, m_ph = 0, m_pl = 0, m_pub_per = 0, m_pub_hi = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_meas = 0; m_have_prev = 0; m_err = 0;
        m_last = 0; m_match = 0; m_pub_per = 0; m_pub_hi = 0;
    endtask

    // Called before a period (h high then l low) is driven; its leading rise closes the previous one
    task automatic model_period(input int h, input int l);
        exp_t e;
        int   p;
        if (m_meas) begin
            p = m_ph + m_pl;
            if (m_have_prev && p == m_last) m_match = (m_match < LOCK_CNT) ? m_match + 1 : LOCK_CNT;
            else                            m_match = 0;
            m_last = p; m_have_prev = 1; m_err = 0;
            m_pub_per = p; m_pub_hi = m_ph;
            e.tmo = 0; e.per = p; e.hi = m_ph; e.lk = (m_match == LOCK_CNT) ? 1 : 0;
            exp_q.push_back(e);
        end
        m_meas = 1;
        if (h >= SAT || l > SAT) begin
            if (!m_err) begin
                e.tmo = 1; e.per = m_pub_per; e.hi = m_pub_hi; e.lk = 0;
                exp_q.push_back(e);
            end
            m_err = 1; m_meas = 0; m_have_prev = 0; m_match = 0;
        end
        m_ph = h; m_pl = l;
    endtask

    task automatic drive(input logic v, input int n);
        clk_in = v;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic run_period(input int h, input int l);
        model_period(h, l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic do_reset(input logic lvl);
        sys_rst = 1'b1;
        clk_in  = lvl;
        @(negedge sys_clk);
        chk("rst_period", int'(period), 0);
        chk("rst_high_time", int'(high_time), 0);
        chk("rst_meas_valid", int'(meas_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err", int'(err), 0);
        @(negedge sys_clk);
        model_reset();
        sys_rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge sys_clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: pops one expectation per strobe or per rising edge of err
    logic err_prev = 1'b0;
    exp_t mon_e;
    always @(negedge sys_clk) begin
        if (meas_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_kind", 0, int'(mon_e.tmo));
                chk("period", int'(period), mon_e.per);
                chk("high_time", int'(high_time), mon_e.hi);
                chk("locked", int'(locked), mon_e.lk);
                chk("err_at_strobe", int'(err), 0);
            end
        end
        if (err && !err_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_err", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("err_kind", 1, int'(mon_e.tmo));
                chk("err_locked", int'(locked), 0);
                chk("err_period_hold", int'(period), mon_e.per);
                chk("err_high_hold", int'(high_time), mon_e.hi);
            end
        end
        err_prev <= err;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, l;
        do_reset(1'b1);
        drive(1'b1, 3);
        drive(1'b0, 2);
        repeat (8) run_period(3, 2);
        run_period(4, 2);
        repeat (6) run_period(3, 2);
        run_period(3, 300);
        repeat (6) run_period(3, 2);
        repeat (10) run_period(1, 1);
        run_period(3, 255);
        run_period(255, 3);
        run_period(2, 3);
        run_period(254, 2);
        run_period(2, 2);
        h = 3; l = 3;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) >= 7) begin
                h = int'($urandom_range(1, 6));
                l = (($urandom_range(0, 19)) == 0) ? int'($urandom_range(250, 260))
                                                   : int'($urandom_range(1, 6));
            end
            run_period(h, l);
        end
        repeat (7) run_period(3, 2);
        model_period(10, 0);
        drive(1'b1, 10);
        drain();
        do_reset(1'b0);
        drive(1'b0, 2);
        repeat (8) run_period(3, 2);
        model_period(1, 1);
        drive(1'b1, 1);
        drive(1'b0, 1);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
